ilm_ecc_loader: RTL and testbench
=================================

ILM_ECC_LOADER -- requirements
Module: ilm_ecc_loader

Interface
REQ-001 SHALL have parameter ILM_AW, default 14, meaning the ILM word-address width.
REQ-002 SHALL have parameter ILM_DP, default 16384, meaning the ILM depth in 32-bit words.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, single-cycle start pulse.
REQ-006 SHALL have port clr_mode, input, 1, sampled with start; 1 = zero-fill, 0 = byte load.
REQ-007 SHALL have port base_addr, input, ILM_AW, first word address, sampled with start.
REQ-008 SHALL have port clr_cnt, input, ILM_AW+1, number of words to zero-fill, sampled with start.
REQ-009 SHALL have port s_valid / s_ready / s_byte[7:0] / s_last, in/out/in/in, 1/1/8/1, the byte stream handshake.
REQ-010 SHALL have port ram_cs / ram_we, output, 1 each, ILM write strobe.
REQ-011 SHALL have port ram_addr, output, ILM_AW, ILM word address.
REQ-012 SHALL have port ram_wdata, output, 40, {1'b0, ecc[6:0], data[31:0]}.
REQ-013 SHALL have port ram_gnt, input, 1; a write completes in a cycle with ram_cs & ram_gnt.
REQ-014 SHALL have port busy / done / err, output, 1 each: busy level, done one-cycle pulse, err sticky until next start.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CLEAR, FLUSH, DONE.
REQ-016 SHALL in IDLE, on start, go to CLEAR if clr_mode=1 and clr_cnt!=0, else to LOAD; start with clr_cnt=0 in clear mode SHALL go directly to DONE.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL in LOAD accept a byte on s_valid & s_ready into lane 0..3, little-endian (lane0 = data[7:0]); the lane counter wraps 3->0.
REQ-019 SHALL assert ram_cs=ram_we=1 the cycle after the 4th byte is accepted, holding addr/wdata stable until ram_gnt.
REQ-020 SHALL deassert s_ready while a write is pending without ram_gnt; a grant and a new byte in the same cycle are both accepted (no bubble).
REQ-021 SHALL increment the word address by 1 on each granted write.
REQ-022 SHALL on s_last with lanes 0..2 filled zero-pad the remaining lanes, enter FLUSH, write the partial word, then go to DONE; s_last on lane 3 writes normally and then goes to DONE.
REQ-023 SHALL when the address would pass ILM_DP-1 set err, suppress further writes, and keep s_ready=1 to drain bytes until s_last, then go to DONE.
REQ-024 SHALL in CLEAR write 40'h0 to clr_cnt consecutive words from base_addr, one per grant, then go to DONE; overrun beyond ILM_DP-1 SHALL set err and stop.
REQ-025 SHALL compute ecc with 32-bit SECDED: bits 0..5 are Hamming parities over fixed data-bit sets, bit 6 is the XOR of all data bits and ecc[5:0]; ram_wdata[39] is always 0.
REQ-026 SHALL in DONE pulse done for one cycle and return to IDLE; busy=1 in every state except IDLE.

Reset
REQ-027 SHALL on rst go to IDLE and drive s_ready, ram_cs, ram_we, busy, done and err to 0, and ram_addr and ram_wdata to 0.
REQ-028 SHALL on rst mid-operation discard the partial word and any pending write; no ram_cs follows reset.

Structure
REQ-029 SHALL place the ecc_code_32gen function, the FSM state encoding and the 40-bit word layout constants in shared package ilm_ecc_pkg.
REQ-030 SHALL put the combinational ECC in a single sub-module ilm_ecc_gen32, which is reused by the ILM read-check path.

Verification
REQ-031 SHALL cover: base_addr=0, bytes 13 00 00 00 with s_last, ram_gnt=1 -> one write, addr 0, wdata 40'h4F00000013, done pulse.
REQ-032 SHALL cover: bytes FF FF FF FF, 00 00 00 00 from base_addr=5 -> writes addr 5 wdata 40'h18FFFFFFFF, then addr 6 wdata 40'h0000000000.
REQ-033 SHALL cover: 6 bytes 01..06 with s_last on the 6th -> second write is 40'h??00000605 with correctly computed ecc, and lanes 2..3 are zero.
REQ-034 SHALL cover: clr_mode=1, base_addr=100, clr_cnt=3, ram_gnt toggling every other cycle -> exactly 3 zero writes at 100..102, s_ready held 0, err=0.
REQ-035 SHALL cover: base_addr=ILM_DP-1 with 8 bytes -> one write at ILM_DP-1, err=1, remaining bytes drained, done pulse.
REQ-036 SHALL cover: rst asserted after 2 bytes -> no write issued, all outputs 0 the next cycle, and a following load behaves normally.

Source files
------------

// File: rtl/ilm_ecc_pkg.sv
// Shared definitions for the ILM ECC path: loader FSM encoding, 40-bit ILM word
// layout and the 32-bit SECDED code generator.
package ilm_ecc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    FLUSH,
    DONE
  } ilm_state_e;

  localparam int WORD_W   = 40;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 32;
  localparam int ECC_LSB  = 32;
  localparam int ECC_W    = 7;
  localparam int PAD_BIT  = 39;

  // Data bits occupy the non-power-of-two positions 3..38 of a Hamming code word;
  // parity p covers every position whose index has bit p set. Bit 6 is overall parity.
  function automatic logic [6:0] ecc_code_32gen(input logic [31:0] data);
    logic [6:0] ecc;
    logic [4:0] d;
    ecc = '0;
    d   = '0;
    for (logic [5:0] pos = 6'd1; pos <= 6'd38; pos++) begin
      if ((pos & (pos - 6'd1)) != 6'd0) begin
        for (int p = 0; p < 6; p++) begin
          if (pos[p]) ecc[p] = ecc[p] ^ data[d];
        end
        d++;
      end
    end
    ecc[6] = (^data) ^ (^ecc[5:0]);
    return ecc;
  endfunction

endpackage

// File: rtl/ilm_ecc_gen32.sv
// Combinational SECDED check-bit generator for one 32-bit ILM data word;
// shared between the loader write path and the ILM read-check path.
module ilm_ecc_gen32
  import ilm_ecc_pkg::*;
(
  input  logic [31:0] data,
  output logic [6:0]  ecc
);

  assign ecc = ecc_code_32gen(data);

endmodule

// File: rtl/ilm_ecc_loader.sv
// ILM initialiser: packs a little-endian byte stream into ECC-protected 40-bit
// words, or zero-fills a word range, writing through a cs/gnt handshake.
module ilm_ecc_loader
  import ilm_ecc_pkg::*;
#(
  parameter int ILM_AW = 14,
  parameter int ILM_DP = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr_mode,
  input  logic [ILM_AW-1:0] base_addr,
  input  logic [ILM_AW:0]   clr_cnt,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_byte,
  input  logic              s_last,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ILM_AW-1:0] ram_addr,
  output logic [39:0]       ram_wdata,
  input  logic              ram_gnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ILM_AW:0] LAST_ADDR = (ILM_AW+1)'(ILM_DP - 1);

  ilm_state_e        state, state_nxt;
  logic [ILM_AW-1:0] addr;
  logic [31:0]       word;
  logic [1:0]        lane;
  logic              pend;
  logic              full;
  logic              err_q;
  logic [ILM_AW:0]   remaining;
  logic [6:0]        ecc;
  logic              grant, at_last, over, accept, word_done, base_beyond, clear_go;

  ilm_ecc_gen32 u_ecc (
    .data (word),
    .ecc  (ecc)
  );

  assign at_last     = ({1'b0, addr} == LAST_ADDR);
  assign base_beyond = ({1'b0, base_addr} > LAST_ADDR);
  assign clear_go    = clr_mode && (clr_cnt != '0);
  assign grant       = pend & ram_gnt;
  // Once the last word is granted, any further byte belongs to an overrun word.
  assign over        = full | (grant & at_last);
  assign s_ready     = (state == LOAD) && (!pend || ram_gnt);
  assign accept      = s_valid & s_ready;
  assign word_done   = accept & ~over & ((lane == 2'd3) | s_last);

  assign ram_cs                          = pend;
  assign ram_we                          = pend;
  assign ram_addr                        = addr;
  assign ram_wdata[PAD_BIT]              = 1'b0;
  assign ram_wdata[ECC_LSB +: ECC_W]     = ecc;
  assign ram_wdata[DATA_LSB +: DATA_W]   = word;
  assign busy                            = (state != IDLE);
  assign done                            = (state == DONE);
  assign err                             = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (clr_mode) state_nxt = (clr_cnt != '0) ? CLEAR : DONE;
          else          state_nxt = LOAD;
        end
      end
      LOAD:  if (accept && s_last) state_nxt = over ? DONE : FLUSH;
      FLUSH: if (grant) state_nxt = DONE;
      CLEAR: begin
        if (!pend || (ram_gnt && ((remaining == (ILM_AW+1)'(1)) || at_last)))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      word      <= '0;
      lane      <= '0;
      pend      <= 1'b0;
      full      <= 1'b0;
      err_q     <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            word      <= '0;
            lane      <= '0;
            remaining <= clr_cnt;
            full      <= base_beyond;
            err_q     <= clear_go & base_beyond;
            pend      <= clear_go & ~base_beyond;
          end
        end
        LOAD: begin
          if (grant) begin
            addr <= addr + 1'b1;
            if (at_last) full <= 1'b1;
          end
          pend <= (pend & ~ram_gnt) | word_done;
          if (accept) begin
            if (over) begin
              err_q <= 1'b1;
            end else begin
              // Starting a fresh word clears the upper lanes, so a short tail is zero-padded.
              if (lane == 2'd0) word <= {24'h0, s_byte};
              else              word[{lane, 3'b000} +: 8] <= s_byte;
              lane <= lane + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (grant) begin
            addr <= addr + 1'b1;
            pend <= 1'b0;
          end
        end
        CLEAR: begin
          if (grant) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (ILM_AW+1)'(1)) begin
              pend <= 1'b0;
            end else if (at_last) begin
              pend  <= 1'b0;
              err_q <= 1'b1;
            end
          end
        end
        default: pend <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ilm_ecc_loader.sv
// Directed bench for ilm_ecc_loader: table of byte-load vectors plus hand-written
// sequences for zero-fill, empty clear and mid-load reset.
module tb_ilm_ecc_loader;

  localparam int AW = 14;
  localparam int DP = 16384;

  logic          clk = 1'b0;
  logic          rst, start, clr_mode, s_valid, s_ready, s_last;
  logic          ram_cs, ram_we, ram_gnt, busy, done, err;
  logic [AW-1:0] base_addr, ram_addr;
  logic [AW:0]   clr_cnt;
  logic [7:0]    s_byte;
  logic [39:0]   ram_wdata;

  ilm_ecc_loader #(.ILM_AW(AW), .ILM_DP(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clr_mode  (clr_mode),
    .base_addr (base_addr),
    .clr_cnt   (clr_cnt),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_byte    (s_byte),
    .s_last    (s_last),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_gnt   (ram_gnt),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    logic [63:0]   bytes;
    logic          toggle;
    int            nwr;
    logic [AW-1:0] a0;
    logic [39:0]   d0;
    logic [AW-1:0] a1;
    logic [39:0]   d1;
    logic          err;
  } vec_t;

  vec_t vecs[5];

  int   checks = 0;
  int   errors = 0;
  logic gnt_toggle = 1'b0;

  // Monitor: records completed writes, done pulses and s_ready activity.
  logic [AW-1:0] wr_addr[$];
  logic [39:0]   wr_data[$];
  int            done_cnt  = 0;
  int            ready_cnt = 0;
  logic          err_at_done = 1'b0;

  always @(negedge clk) begin
    if (ram_cs && ram_we && ram_gnt) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_wdata);
    end
    if (done) begin
      done_cnt    = done_cnt + 1;
      err_at_done = err;
    end
    if (s_ready) ready_cnt = ready_cnt + 1;
  end

  initial begin
    ram_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ram_gnt = gnt_toggle ? ~ram_gnt : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startOp(input logic clr, input logic [AW-1:0] base, input logic [AW:0] cnt);
    start     = 1'b1;
    clr_mode  = clr;
    base_addr = base;
    clr_cnt   = cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last);
    int waitc;
    waitc   = 0;
    s_valid = 1'b1;
    s_byte  = b;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && waitc < 50) begin
      tick();
      @(negedge clk);
      waitc++;
    end
    checkOutput("byte_accept", {63'h0, s_ready}, 64'h1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic waitDone(input int base_done);
    int n;
    n = 0;
    while (done_cnt == base_done && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("done_seen", {63'h0, done_cnt != base_done}, 64'h1);
    tick();
    tick();
    tick();
    checkOutput("done_pulses", 64'(done_cnt - base_done), 64'h1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int base_wr, base_done, nw;
    string tag;
    tag        = $sformatf("vec%0d", idx);
    tick();
    gnt_toggle = v.toggle;
    base_wr    = wr_addr.size();
    base_done  = done_cnt;
    startOp(1'b0, v.base, '0);
    for (int i = 0; i < v.n; i++) begin
      sendByte(v.bytes[i*8 +: 8], i == v.n - 1);
    end
    waitDone(base_done);
    gnt_toggle = 1'b0;
    nw = wr_addr.size() - base_wr;
    checkOutput({tag, "_nwrites"}, 64'(nw), 64'(v.nwr));
    if (nw >= 1 && v.nwr >= 1) begin
      checkOutput({tag, "_addr0"}, 64'(wr_addr[base_wr]), 64'(v.a0));
      checkOutput({tag, "_data0"}, 64'(wr_data[base_wr]), 64'(v.d0));
    end
    if (nw >= 2 && v.nwr >= 2) begin
      checkOutput({tag, "_addr1"}, 64'(wr_addr[base_wr+1]), 64'(v.a1));
      checkOutput({tag, "_data1"}, 64'(wr_data[base_wr+1]), 64'(v.d1));
    end
    checkOutput({tag, "_err"}, {63'h0, err_at_done}, {63'h0, v.err});
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_s_ready"}, {63'h0, s_ready}, 64'h0);
    checkOutput({tag, "_ram_cs"}, {63'h0, ram_cs}, 64'h0);
    checkOutput({tag, "_ram_we"}, {63'h0, ram_we}, 64'h0);
    checkOutput({tag, "_busy"}, {63'h0, busy}, 64'h0);
    checkOutput({tag, "_done"}, {63'h0, done}, 64'h0);
    checkOutput({tag, "_err"}, {63'h0, err}, 64'h0);
    checkOutput({tag, "_ram_addr"}, 64'(ram_addr), 64'h0);
    checkOutput({tag, "_ram_wdata"}, 64'(ram_wdata), 64'h0);
  endtask

  initial begin
    int base_wr, base_done, base_ready, nw;

    vecs[0] = '{base: 14'd0, n: 4, bytes: 64'h00000000_00000013, toggle: 1'b0, nwr: 1,
                a0: 14'd0, d0: 40'h4F00000013, a1: 14'd0, d1: 40'h0, err: 1'b0};
    vecs[1] = '{base: 14'd5, n: 8, bytes: 64'h00000000_FFFFFFFF, toggle: 1'b0, nwr: 2,
                a0: 14'd5, d0: 40'h18FFFFFFFF, a1: 14'd6, d1: 40'h0000000000, err: 1'b0};
    vecs[2] = '{base: 14'd10, n: 6, bytes: 64'h00000605_04030201, toggle: 1'b0, nwr: 2,
                a0: 14'd10, d0: 40'h6D04030201, a1: 14'd11, d1: 40'h4400000605, err: 1'b0};
    vecs[3] = '{base: 14'(DP-1), n: 8, bytes: 64'hDDCCBBAA_00000013, toggle: 1'b0, nwr: 1,
                a0: 14'(DP-1), d0: 40'h4F00000013, a1: 14'd0, d1: 40'h0, err: 1'b1};
    vecs[4] = '{base: 14'd200, n: 6, bytes: 64'h00000605_04030201, toggle: 1'b1, nwr: 2,
                a0: 14'd200, d0: 40'h6D04030201, a1: 14'd201, d1: 40'h4400000605, err: 1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    clr_mode  = 1'b0;
    base_addr = '0;
    clr_cnt   = '0;
    s_valid   = 1'b0;
    s_byte    = '0;
    s_last    = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset");

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Zero-fill of three words with the grant toggling every cycle.
    tick();
    gnt_toggle = 1'b1;
    base_wr    = wr_addr.size();
    base_done  = done_cnt;
    base_ready = ready_cnt;
    startOp(1'b1, 14'd100, 15'd3);
    waitDone(base_done);
    gnt_toggle = 1'b0;
    nw = wr_addr.size() - base_wr;
    checkOutput("clear_nwrites", 64'(nw), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < nw) begin
        checkOutput($sformatf("clear_addr%0d", i), 64'(wr_addr[base_wr+i]), 64'(100 + i));
        checkOutput($sformatf("clear_data%0d", i), 64'(wr_data[base_wr+i]), 64'h0);
      end
    end
    checkOutput("clear_s_ready", 64'(ready_cnt - base_ready), 64'h0);
    checkOutput("clear_err", {63'h0, err_at_done}, 64'h0);

    // Clear with a zero count finishes without touching the ILM.
    tick();
    base_wr   = wr_addr.size();
    base_done = done_cnt;
    startOp(1'b1, 14'd7, 15'd0);
    waitDone(base_done);
    checkOutput("clear0_nwrites", 64'(wr_addr.size() - base_wr), 64'h0);

    // Reset after two bytes drops the partial word.
    tick();
    base_wr = wr_addr.size();
    startOp(1'b0, 14'd50, '0);
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midrst");
    for (int i = 0; i < 6; i++) tick();
    checkOutput("midrst_nwrites", 64'(wr_addr.size() - base_wr), 64'h0);
    applyStimulus(vecs[0], 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
